// File: rtl/mux8x1_always.sv
// rtl/mux8x1_always.sv - 8-to-1 lane selector with optional registered output and valid strobe
module mux8x1_always #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [8*WIDTH-1:0] in,
    input  logic [2:0]         sel,
    input  logic               valid_in,
    output logic [WIDTH-1:0]   result,
    output logic               valid_out
);

    logic [WIDTH-1:0] sel_lane;

    // X/Z on sel falls into default so an unknown select never leaks a lane.
    always_comb begin
        sel_lane = '0;
        case (sel)
            3'b000:  sel_lane = in[0*WIDTH +: WIDTH];
            3'b001:  sel_lane = in[1*WIDTH +: WIDTH];
            3'b010:  sel_lane = in[2*WIDTH +: WIDTH];
            3'b011:  sel_lane = in[3*WIDTH +: WIDTH];
            3'b100:  sel_lane = in[4*WIDTH +: WIDTH];
            3'b101:  sel_lane = in[5*WIDTH +: WIDTH];
            3'b110:  sel_lane = in[6*WIDTH +: WIDTH];
            3'b111:  sel_lane = in[7*WIDTH +: WIDTH];
            default: sel_lane = '0;
        endcase
    end

    generate
        if (REG_OUT) begin : g_reg
            // result holds its last selection while valid_in is low.
            always_ff @(posedge clk) begin
                if (rst) begin
                    result    <= '0;
                    valid_out <= 1'b0;
                end else begin
                    valid_out <= valid_in;
                    if (valid_in) begin
                        result <= sel_lane;
                    end
                end
            end
        end else begin : g_comb
            assign result    = sel_lane;
            assign valid_out = valid_in;
        end
    endgenerate

endmodule

// File: tb/tb_mux8x1_always.sv
// tb/tb_mux8x1_always.sv - self-checking bench for mux8x1_always
module tb_mux8x1_always;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic [2:0]  sel;
    logic        vin;
    logic [0:0]  res;
    logic        vout;

    logic [31:0] din4;
    logic [2:0]  sel4;
    logic        vin4;
    logic [3:0]  res4;
    logic        vout4;

    int n_pass  = 0;
    int n_total = 0;

    logic [0:0] exp_res;
    logic       exp_vld;

    always #5 clk = ~clk;

    mux8x1_always #(.WIDTH(1), .REG_OUT(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (din),
        .sel       (sel),
        .valid_in  (vin),
        .result    (res),
        .valid_out (vout)
    );

    mux8x1_always #(.WIDTH(4), .REG_OUT(1'b0)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in        (din4),
        .sel       (sel4),
        .valid_in  (vin4),
        .result    (res4),
        .valid_out (vout4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: lane k of an N-bit-per-lane bus is bits [k*N +: N], i.e. shift and mask.
    function automatic logic [31:0] lane_of(input logic [31:0] bus, input int idx, input int w);
        logic [31:0] mask;
        mask = (32'h1 << w) - 32'h1;
        return (bus >> (idx * w)) & mask;
    endfunction

    // One clock: the model observes what the DUT samples, then both are compared #1 later.
    task automatic tick(input string tag);
        @(posedge clk);
        if (rst) begin
            exp_res = '0;
            exp_vld = 1'b0;
        end else if (vin) begin
            exp_res = lane_of({24'h0, din}, int'(sel), 1);
            exp_vld = 1'b1;
        end else begin
            exp_vld = 1'b0;
        end
        #1;
        chk({tag, ".result"}, {31'h0, res}, {31'h0, exp_res});
        chk({tag, ".valid"},  {31'h0, vout}, {31'h0, exp_vld});
    endtask

    initial begin
        exp_res = '0;
        exp_vld = 1'b0;
        din4 = 32'h0; sel4 = 3'd0; vin4 = 1'b0;

        // Reset held two cycles with a valid request present.
        rst = 1'b1; din = 8'hFF; sel = 3'b000; vin = 1'b1;
        repeat (2) begin
            tick("reset");
            chk("reset.zero", {31'h0, res}, 32'h0);
        end
        rst = 1'b0;

        // Select sweep over an alternating pattern.
        din = 8'b1010_1010;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            tick("sweep");
            chk("sweep.const", {31'h0, res}, 32'(i % 2));
        end

        // Valid gating: result holds, valid drops.
        sel = 3'b001; vin = 1'b1;
        tick("gate_on");
        sel = 3'b000; vin = 1'b0;
        tick("gate_off");
        chk("gate.hold", {31'h0, res}, 32'h1);
        chk("gate.vdrop", {31'h0, vout}, 32'h0);

        // Data change at fixed select.
        vin = 1'b1; sel = 3'b111; din = 8'h80;
        tick("data_a");
        chk("data.one", {31'h0, res}, 32'h1);
        din = 8'h7F;
        tick("data_b");
        chk("data.zero", {31'h0, res}, 32'h0);

        // Mid-stream reset at sel=3 of a sweep.
        din = 8'b1010_1010;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            rst = (i == 3);
            tick("midrst");
            if (i == 3) begin
                chk("midrst.res", {31'h0, res}, 32'h0);
                chk("midrst.vld", {31'h0, vout}, 32'h0);
            end else if (i == 4) begin
                chk("midrst.resume", {31'h0, res}, 32'h0);
                chk("midrst.rvld", {31'h0, vout}, 32'h1);
            end
        end
        rst = 1'b0;

        // Randomised traffic with occasional reset.
        for (int i = 0; i < 300; i++) begin
            din = 8'($urandom);
            sel = 3'($urandom);
            vin = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 31) == 0);
            tick("rand");
        end
        rst = 1'b0;

        // Combinational WIDTH=4 instance.
        din4 = 32'h7654_3210; sel4 = 3'd5; vin4 = 1'b1;
        #1;
        chk("w4.result", {28'h0, res4}, 32'h5);
        chk("w4.valid", {31'h0, vout4}, 32'h1);
        vin4 = 1'b0;
        #1;
        chk("w4.vlow", {31'h0, vout4}, 32'h0);
        for (int i = 0; i < 40; i++) begin
            din4 = $urandom;
            sel4 = 3'($urandom);
            vin4 = 1'($urandom);
            #1;
            chk("w4.rand", {28'h0, res4}, lane_of(din4, int'(sel4), 4));
            chk("w4.rvld", {31'h0, vout4}, {31'h0, vin4});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
